// File: rtl/cpu_dm_axi_bridge.sv
// CPU data-memory port to AXI4-Lite master bridge.
// Runs one single-word load (AR/R) or store (AW/W/B) at a time and stalls the CPU until it completes.
module cpu_dm_axi_bridge #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              DM_WEB,
  input  logic              DM_write,
  input  logic [3:0]        DM_BWEB,
  input  logic [ADDR_W-1:0] DM_addr,
  input  logic [DATA_W-1:0] DM_DI,
  input  logic              IM_stall,
  output logic [DATA_W-1:0] DM_DO,
  output logic              DM_stall,
  output logic              bus_err,
  output logic [ADDR_W-1:0] ARADDR,
  output logic              ARVALID,
  input  logic              ARREADY,
  input  logic [DATA_W-1:0] RDATA,
  input  logic [1:0]        RRESP,
  input  logic              RVALID,
  output logic              RREADY,
  output logic [ADDR_W-1:0] AWADDR,
  output logic              AWVALID,
  input  logic              AWREADY,
  output logic [DATA_W-1:0] WDATA,
  output logic [3:0]        WSTRB,
  output logic              WVALID,
  input  logic              WREADY,
  input  logic [1:0]        BRESP,
  input  logic              BVALID,
  output logic              BREADY
);

  typedef enum logic [2:0] {IDLE, RD_A, RD_D, WR, WR_B, DONE} state_t;

  state_t            state, state_nx;
  logic              req;
  logic              aw_done, w_done;
  logic              aw_hs, w_hs, aw_fin, w_fin;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic [3:0]        strb_q;

  assign req = DM_write | DM_WEB;

  // Every handshake signal is decoded from registered state, so VALIDs and payloads stay stable
  assign ARVALID = (state == RD_A);
  assign RREADY  = (state == RD_D);
  assign AWVALID = (state == WR) && !aw_done;
  assign WVALID  = (state == WR) && !w_done;
  assign BREADY  = (state == WR_B);
  assign ARADDR  = addr_q;
  assign AWADDR  = addr_q;
  assign WDATA   = data_q;
  assign WSTRB   = strb_q;

  assign aw_hs  = AWVALID & AWREADY;
  assign w_hs   = WVALID & WREADY;
  assign aw_fin = aw_done | aw_hs;
  assign w_fin  = w_done | w_hs;

  // Held low during reset so an aborted access never looks like a pending one
  assign DM_stall = req & (state != DONE) & ~rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (req) state_nx = DM_write ? WR : RD_A;
      RD_A: if (ARREADY) state_nx = RD_D;
      RD_D: if (RVALID) state_nx = DONE;
      WR:   if (aw_fin && w_fin) state_nx = WR_B;
      WR_B: if (BVALID) state_nx = DONE;
      DONE: if (!IM_stall) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Request latch, per-channel write completion flags, load data and sticky error
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= '0;
      data_q  <= '0;
      strb_q  <= '0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
      DM_DO   <= '0;
      bus_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          aw_done <= 1'b0;
          w_done  <= 1'b0;
          if (req) begin
            addr_q <= DM_addr;
            data_q <= DM_DI;
            strb_q <= ~DM_BWEB;
          end
        end
        WR: begin
          aw_done <= aw_fin;
          w_done  <= w_fin;
        end
        RD_D: if (RVALID) begin
          DM_DO <= RDATA;
          if (RRESP != 2'b00) bus_err <= 1'b1;
        end
        WR_B: if (BVALID && BRESP != 2'b00) bus_err <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_dm_axi_bridge.sv
// Directed bench for cpu_dm_axi_bridge with a configurable wait-state AXI4-Lite slave.
// Each task drives one scenario and checks its hand-computed expectations inline.
module tb_cpu_dm_axi_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        DM_WEB, DM_write, IM_stall;
  logic [3:0]  DM_BWEB;
  logic [31:0] DM_addr, DM_DI, DM_DO;
  logic        DM_stall, bus_err;
  logic [31:0] ARADDR, RDATA, AWADDR, WDATA;
  logic        ARVALID, ARREADY, RVALID, RREADY, AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
  logic [1:0]  RRESP, BRESP;
  logic [3:0]  WSTRB;

  int total = 0;
  int bad = 0;

  // Slave configuration (written only by the stimulus process)
  int          ar_wait, r_wait, aw_wait, w_wait, b_wait;
  logic [31:0] rdata_cfg;
  logic [1:0]  rresp_cfg, bresp_cfg;

  // Slave state and monotonic monitors (written only by the slave process)
  int          ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt;
  bit          r_pend, aw_got, w_got;
  int          ar_hs_n = 0, r_hs_n = 0, aw_hs_n = 0, w_hs_n = 0, b_hs_n = 0;
  int          arvalid_n = 0, bready_early_n = 0;
  logic [31:0] seen_araddr, seen_awaddr, seen_wdata;
  logic [3:0]  seen_wstrb;

  cpu_dm_axi_bridge #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .DM_WEB(DM_WEB), .DM_write(DM_write), .DM_BWEB(DM_BWEB), .DM_addr(DM_addr), .DM_DI(DM_DI),
    .IM_stall(IM_stall), .DM_DO(DM_DO), .DM_stall(DM_stall), .bus_err(bus_err),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY)
  );

  always #5 clk = ~clk;

  // Slave: decides READY/VALID on the falling edge; a READY or VALID that was high there
  // means the handshake happened on the rising edge just passed.
  always @(negedge clk) begin
    if (rst) begin
      ARREADY = 0; RVALID = 0; AWREADY = 0; WREADY = 0; BVALID = 0;
      RDATA = '0; RRESP = '0; BRESP = '0;
      ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
      r_pend = 0; aw_got = 0; w_got = 0;
    end else begin
      if (ARVALID) arvalid_n++;
      if (ARREADY) begin ARREADY = 0; ar_hs_n++; ar_cnt = 0; r_pend = 1; r_cnt = 0; end
      else if (ARVALID) begin
        if (ar_cnt >= ar_wait) begin ARREADY = 1; seen_araddr = ARADDR; end else ar_cnt++;
      end
      if (RVALID) begin RVALID = 0; r_hs_n++; r_pend = 0; end
      else if (r_pend) begin
        if (r_cnt >= r_wait) begin RVALID = 1; RDATA = rdata_cfg; RRESP = rresp_cfg; end else r_cnt++;
      end
      if (AWREADY) begin AWREADY = 0; aw_hs_n++; aw_got = 1; end
      else if (AWVALID) begin
        if (aw_cnt >= aw_wait) begin AWREADY = 1; seen_awaddr = AWADDR; end else aw_cnt++;
      end
      if (WREADY) begin WREADY = 0; w_hs_n++; w_got = 1; end
      else if (WVALID) begin
        if (w_cnt >= w_wait) begin WREADY = 1; seen_wdata = WDATA; seen_wstrb = WSTRB; end else w_cnt++;
      end
      if (BREADY && !(aw_got && w_got)) bready_early_n++;
      if (BVALID) begin BVALID = 0; b_hs_n++; aw_got = 0; w_got = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0; end
      else if (aw_got && w_got) begin
        if (b_cnt >= b_wait) begin BVALID = 1; BRESP = bresp_cfg; end else b_cnt++;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic set_slave(input int arw, input int rw, input int aww, input int ww, input int bw,
                           input logic [31:0] d, input logic [1:0] rr, input logic [1:0] br);
    ar_wait = arw; r_wait = rw; aw_wait = aww; w_wait = ww; b_wait = bw;
    rdata_cfg = d; rresp_cfg = rr; bresp_cfg = br;
  endtask

  // Called at negedge+1; presents a request and counts stall cycles until DONE
  task automatic access(input logic we, input logic wr, input logic [31:0] addr, input logic [31:0] di,
                        input logic [3:0] bweb, output int stalls, output bit timeout);
    DM_WEB = we; DM_write = wr; DM_addr = addr; DM_DI = di; DM_BWEB = bweb;
    stalls = 0; timeout = 0;
    #1;
    while (DM_stall) begin
      stalls++;
      if (stalls > 50) begin timeout = 1; break; end
      @(negedge clk); #1;
    end
  endtask

  task automatic release_req();
    DM_WEB = 0; DM_write = 0;
    @(negedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1; DM_WEB = 0; DM_write = 0; DM_BWEB = 4'hF; DM_addr = '0; DM_DI = '0; IM_stall = 0;
    set_slave(0, 0, 0, 0, 0, 32'h0, 2'b00, 2'b00);
    repeat (2) @(negedge clk);
    #1;
    total++; if (ARVALID !== 1'b0) begin bad++; $display("FAIL reset_arvalid got=%b want=0", ARVALID); end
    total++; if (RREADY !== 1'b0) begin bad++; $display("FAIL reset_rready got=%b want=0", RREADY); end
    total++; if (AWVALID !== 1'b0 || WVALID !== 1'b0) begin bad++; $display("FAIL reset_awwvalid got=%b%b want=00", AWVALID, WVALID); end
    total++; if (BREADY !== 1'b0) begin bad++; $display("FAIL reset_bready got=%b want=0", BREADY); end
    total++; if (DM_DO !== 32'h0) begin bad++; $display("FAIL reset_dm_do got=%h want=00000000", DM_DO); end
    total++; if (bus_err !== 1'b0) begin bad++; $display("FAIL reset_bus_err got=%b want=0", bus_err); end
    total++; if (DM_stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b want=0", DM_stall); end
    rst = 0;
    @(negedge clk); #1;
  endtask

  task automatic test_read_zero_wait();
    int st; bit to; int ar0, r0;
    set_slave(0, 0, 0, 0, 0, 32'hDEAD_BEEF, 2'b00, 2'b00);
    ar0 = ar_hs_n; r0 = r_hs_n;
    access(1, 0, 32'h0001_0040, 32'h0, 4'hF, st, to);
    total++; if (to) begin bad++; $display("FAIL rd_timeout got=stuck want=done"); end
    total++; if (st != 3) begin bad++; $display("FAIL rd_stall_cycles got=%0d want=3", st); end
    total++; if (seen_araddr !== 32'h0001_0040) begin bad++; $display("FAIL rd_araddr got=%h want=00010040", seen_araddr); end
    total++; if (DM_DO !== 32'hDEAD_BEEF) begin bad++; $display("FAIL rd_dm_do got=%h want=deadbeef", DM_DO); end
    total++; if (ar_hs_n - ar0 != 1 || r_hs_n - r0 != 1) begin bad++; $display("FAIL rd_handshakes got=%0d/%0d want=1/1", ar_hs_n - ar0, r_hs_n - r0); end
    release_req();
  endtask

  task automatic test_byte_enable();
    int st; bit to; int aw0, w0, b0, e0;
    set_slave(0, 0, 0, 2, 0, 32'h0, 2'b00, 2'b00);
    aw0 = aw_hs_n; w0 = w_hs_n; b0 = b_hs_n; e0 = bready_early_n;
    access(0, 1, 32'h0000_2004, 32'h1234_5678, 4'b1100, st, to);
    total++; if (to) begin bad++; $display("FAIL wr_timeout got=stuck want=done"); end
    total++; if (seen_wstrb !== 4'b0011) begin bad++; $display("FAIL wr_wstrb got=%b want=0011", seen_wstrb); end
    total++; if (seen_wdata !== 32'h1234_5678) begin bad++; $display("FAIL wr_wdata got=%h want=12345678", seen_wdata); end
    total++; if (seen_awaddr !== 32'h0000_2004) begin bad++; $display("FAIL wr_awaddr got=%h want=00002004", seen_awaddr); end
    total++; if (aw_hs_n - aw0 != 1 || w_hs_n - w0 != 1) begin bad++; $display("FAIL wr_single_hs got=%0d/%0d want=1/1", aw_hs_n - aw0, w_hs_n - w0); end
    total++; if (b_hs_n - b0 != 1) begin bad++; $display("FAIL wr_b_hs got=%0d want=1", b_hs_n - b0); end
    total++; if (bready_early_n != e0) begin bad++; $display("FAIL wr_bready_early got=%0d want=0", bready_early_n - e0); end
    total++; if (DM_DO !== 32'hDEAD_BEEF) begin bad++; $display("FAIL wr_dm_do_kept got=%h want=deadbeef", DM_DO); end
    release_req();
  endtask

  task automatic test_frozen_cpu();
    int st; bit to; int av0, ar0;
    set_slave(0, 0, 0, 0, 0, 32'h55AA_1234, 2'b00, 2'b00);
    IM_stall = 1;
    access(1, 0, 32'h0001_0080, 32'h0, 4'hF, st, to);
    total++; if (to || DM_DO !== 32'h55AA_1234) begin bad++; $display("FAIL frz_read got=%h want=55aa1234", DM_DO); end
    av0 = arvalid_n; ar0 = ar_hs_n;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      total++; if (DM_stall !== 1'b0) begin bad++; $display("FAIL frz_stall_%0d got=%b want=0", i, DM_stall); end
    end
    total++; if (arvalid_n != av0 || ar_hs_n != ar0) begin bad++; $display("FAIL frz_reissue got=%0d want=0", arvalid_n - av0); end
    IM_stall = 0;
    @(negedge clk); #1;
    total++; if (DM_stall !== 1'b1) begin bad++; $display("FAIL frz_next_accept got=%b want=1", DM_stall); end
    set_slave(0, 0, 0, 0, 0, 32'h600D_CAFE, 2'b00, 2'b00);
    access(1, 0, 32'h0001_00C0, 32'h0, 4'hF, st, to);
    total++; if (to || st != 3) begin bad++; $display("FAIL frz_next_stalls got=%0d want=3", st); end
    total++; if (seen_araddr !== 32'h0001_00C0 || DM_DO !== 32'h600D_CAFE) begin bad++; $display("FAIL frz_next_data got=%h/%h want=000100c0/600dcafe", seen_araddr, DM_DO); end
    release_req();
  endtask

  task automatic test_slave_error();
    int st; bit to;
    set_slave(0, 1, 0, 0, 0, 32'h0BAD_F00D, 2'b10, 2'b00);
    access(1, 0, 32'h0000_0100, 32'h0, 4'hF, st, to);
    total++; if (to || DM_DO !== 32'h0BAD_F00D) begin bad++; $display("FAIL err_read_done got=%h want=0badf00d", DM_DO); end
    total++; if (bus_err !== 1'b1) begin bad++; $display("FAIL err_rresp got=%b want=1", bus_err); end
    release_req();
    set_slave(0, 0, 0, 0, 0, 32'h0, 2'b00, 2'b00);
    access(0, 1, 32'h0000_0104, 32'hA5A5_A5A5, 4'b0000, st, to);
    total++; if (to) begin bad++; $display("FAIL err_write_done got=stuck want=done"); end
    total++; if (bus_err !== 1'b1) begin bad++; $display("FAIL err_sticky got=%b want=1", bus_err); end
    release_req();
  endtask

  task automatic test_conflict();
    int st; bit to; int av0, aw0, w0;
    set_slave(0, 0, 0, 0, 0, 32'h0, 2'b00, 2'b00);
    av0 = arvalid_n; aw0 = aw_hs_n; w0 = w_hs_n;
    access(1, 1, 32'h2000_0008, 32'hCAFE_F00D, 4'b0000, st, to);
    total++; if (to || st != 3) begin bad++; $display("FAIL cf_stalls got=%0d want=3", st); end
    total++; if (arvalid_n != av0) begin bad++; $display("FAIL cf_arvalid got=%0d want=0", arvalid_n - av0); end
    total++; if (aw_hs_n - aw0 != 1 || w_hs_n - w0 != 1) begin bad++; $display("FAIL cf_write_hs got=%0d/%0d want=1/1", aw_hs_n - aw0, w_hs_n - w0); end
    total++; if (seen_wstrb !== 4'hF || seen_awaddr !== 32'h2000_0008) begin bad++; $display("FAIL cf_payload got=%b/%h want=1111/20000008", seen_wstrb, seen_awaddr); end
    total++; if (DM_DO !== 32'h0BAD_F00D) begin bad++; $display("FAIL cf_dm_do_kept got=%h want=0badf00d", DM_DO); end
    release_req();
  endtask

  task automatic test_mid_reset();
    int st; bit to; bit hit;
    set_slave(0, 20, 0, 0, 0, 32'h1111_2222, 2'b00, 2'b00);
    DM_WEB = 1; DM_write = 0; DM_addr = 32'h0000_0200;
    hit = 0;
    for (int i = 0; i < 10 && !hit; i++) begin
      @(negedge clk); #1;
      if (RREADY === 1'b1) hit = 1;
    end
    total++; if (!hit) begin bad++; $display("FAIL mr_reach_rd_d got=no want=yes"); end
    rst = 1; DM_WEB = 0;
    #1;
    total++; if (RREADY !== 1'b0) begin bad++; $display("FAIL mr_rready got=%b want=0", RREADY); end
    total++; if (DM_stall !== 1'b0) begin bad++; $display("FAIL mr_stall got=%b want=0", DM_stall); end
    total++; if (ARVALID !== 1'b0 || AWVALID !== 1'b0) begin bad++; $display("FAIL mr_valids got=%b%b want=00", ARVALID, AWVALID); end
    total++; if (DM_DO !== 32'h0 || bus_err !== 1'b0) begin bad++; $display("FAIL mr_clear got=%h/%b want=00000000/0", DM_DO, bus_err); end
    @(negedge clk); #1;
    rst = 0;
    @(negedge clk); #1;
    set_slave(0, 0, 0, 0, 0, 32'h0, 2'b00, 2'b11);
    access(0, 1, 32'h0000_0300, 32'h7777_8888, 4'b1010, st, to);
    total++; if (to || st != 3) begin bad++; $display("FAIL mr_after_write got=%0d want=3", st); end
    total++; if (bus_err !== 1'b1) begin bad++; $display("FAIL mr_bresp_err got=%b want=1", bus_err); end
    total++; if (seen_wstrb !== 4'b0101) begin bad++; $display("FAIL mr_wstrb got=%b want=0101", seen_wstrb); end
    release_req();
  endtask

  initial begin
    $display("[TB] start");
    test_reset();
    test_read_zero_wait();
    test_byte_enable();
    test_frozen_cpu();
    test_slave_error();
    test_conflict();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
